bcd_result_converter: RTL
=========================

# bcd_result_converter

Sequential binary-to-BCD converter that sits directly downstream of the signed BCD calculator. It captures the calculator's 8-bit magnitude result and sign bit on a start strobe. It converts the magnitude into three BCD digits (hundreds/tens/ones) with an iterative shift-and-add-3 (double-dabble) algorithm, one shift per clock. It then presents the held digits and sign to the seven-segment display stage with a one-cycle done pulse.

## Interface

Parameters:
- BIN_W, default 8, width of binary magnitude input. The legal range is 4..9, because three BCD digits cover up to 999.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset_n  in  1  asynchronous, active-high reset. The name is kept per codebase convention; a high level resets.
- start  in  1  request conversion. Sampled only in IDLE.
- bin_in  in  BIN_W  unsigned magnitude from the calculator. Captured on the accepting edge.
- sign_in  in  1  sign from the calculator (1 = negative). Captured on the accepting edge.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse; the digits are valid and updated.
- hundreds  out  4  BCD hundreds digit, held.
- tens  out  4  BCD tens digit, held.
- ones  out  4  BCD ones digit, held.
- sign_out  out  1  captured sign, held. It is forced to 0 when the magnitude is 0.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - When start=1, load the shift register as {12'b0, bin_in} and latch sign_in.
  - Clear the bit counter and go to SHIFT.
  - When start=0, stay in IDLE.
- SHIFT:
  - Each cycle, add 3 to every 4-bit BCD field that is ≥5, then shift the whole register left by 1.
  - The counter increments every cycle.
  - After BIN_W shifts, write hundreds/tens/ones from the BCD fields and write sign_out.
  - sign_out = latched sign AND (captured magnitude != 0).
  - Then go to DONE.
- DONE: done=1 for exactly this cycle, then return to IDLE unconditionally.
- start is ignored in SHIFT and DONE; it is not queued.
- Outputs hold the last result until the next conversion completes. There are no partial updates during SHIFT.
- Arithmetic: the shift register is 12+BIN_W bits wide. Every digit is always ≤ 9, and the hundreds digit is ≤ 5 for BIN_W ≤ 9.
- Reset values:
  - state = IDLE, busy = 0, done = 0.
  - hundreds = tens = ones = 0, sign_out = 0.
  - Counter and shift register = 0.

## Timing

- Call the accepting edge E0, where start=1 in IDLE.
- Shift edges are E1..E_BIN_W. Outputs update at edge E_BIN_W.
- done is high in the cycle after E_BIN_W; it is low again after E_BIN_W+1.
- busy goes high after E0 and low after E_BIN_W+1. With BIN_W=8 that is 9 cycles high.
- Throughput with start held high: one conversion per BIN_W+2 cycles. The next start is accepted at the first IDLE edge.
- start rising in the same cycle as done: ignored. It is sampled again in IDLE.
- Reset asserted mid-SHIFT or mid-DONE: all outputs and state clear immediately and asynchronously. The in-flight conversion is dropped and no done pulse is produced.
- Reset release: the first start is accepted on the first clock edge with reset_n low.

## Structure

- Shared package: the FSM state enum (IDLE/SHIFT/DONE), the constant NUM_DIGITS=3, and the constant BCD_W=4.
- One sub-module: bcd_add3. It is combinational: a 4-bit in and 4-bit out adjust (add 3 when ≥5), instantiated NUM_DIGITS times on the shift path.
- Counter width: $clog2(BIN_W+1).

## Test plan

- Reset then start with bin_in=225, sign_in=1 → after E8: hundreds=2, tens=2, ones=5, sign_out=1; done high for 1 cycle; busy high for 9 cycles.
- bin_in=0, sign_in=1 → digits 0,0,0 and sign_out=0 (negative zero suppressed).
- bin_in=255, sign_in=0 → 2,5,5, sign_out=0. Then bin_in=9 → 0,0,9. Previous digits hold until the new done.
- Start pulsed again at E3 with bin_in=99 → ignored; the result stays the original value. Only one done pulse occurs.
- Assert reset_n at shift cycle 4 of a 200 conversion → all outputs 0 and busy 0 immediately, with no done. A subsequent start of 47 → 0,4,7.
- start held high with bin_in stepping 0..255 → a conversion every 10 cycles. Every result matches the reference division (n/100, n/10%10, n%10).

Source files
------------

// File: rtl/bcd_result_converter_pkg.sv
// Shared definitions for the binary-to-BCD result converter.
package bcd_result_converter_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int BCD_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_result_converter_add3.sv
// Double-dabble digit adjust: add 3 to a BCD digit that is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bcd_result_converter_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  // Conditional +3 adjust ahead of the shift.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_W'(5)) digit_o = digit_i + BCD_W'(3);
  end

endmodule

// File: rtl/bcd_result_converter.sv
// Sequential binary-to-BCD converter for the calculator result. Captures
// magnitude and sign on start, runs one double-dabble step per clock and
// publishes three held BCD digits plus sign with a one-cycle done pulse.
module bcd_result_converter
  import bcd_result_converter_pkg::*;
#(
  parameter int BIN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,   // active-high despite the name
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             sign_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             sign_out
);

  localparam int BCD_BITS = NUM_DIGITS * BCD_W;
  localparam int SR_W     = BCD_BITS + BIN_W;
  localparam int CNT_W    = $clog2(BIN_W + 1);

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [SR_W-1:0]   sr_adj, sr_shift;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [3:0]        hund_q, hund_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic              sout_q, sout_d;
  logic              last_shift;

  // Adjust each BCD field in the upper part of the shift register.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit_i (sr_q[BIN_W + g*BCD_W +: BCD_W]),
      .digit_o (sr_adj[BIN_W + g*BCD_W +: BCD_W])
    );
  end
  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
  assign sr_shift          = {sr_adj[SR_W-2:0], 1'b0};
  assign last_shift        = (cnt_q == CNT_W'(BIN_W - 1));

  // Next-state and datapath control; outputs only change on the final shift.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    sout_d  = sout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_BITS{1'b0}}, bin_in};
          sign_d  = sign_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_shift) begin
          hund_d  = sr_shift[BIN_W + 2*BCD_W +: BCD_W];
          tens_d  = sr_shift[BIN_W + BCD_W   +: BCD_W];
          ones_d  = sr_shift[BIN_W           +: BCD_W];
          // Nonzero digits are equivalent to a nonzero captured magnitude,
          // so negative zero is suppressed here.
          sout_d  = sign_q & (|sr_shift[SR_W-1:BIN_W]);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      sout_q  <= sout_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign hundreds = hund_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign sign_out = sout_q;

endmodule
